// File: rtl/mmio_master.sv
// MMIO initiator: turns a command/response handshake into single-outstanding
// MMIO/config transactions with odd parity, ack timeout and alignment checking.
package mmio_master_pkg;

  typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [0:23] address;
    logic        address_parity;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic        ack;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceOutput;

endpackage

module mmio_master
  import mmio_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_read,
  input  logic               cmd_cfg,
  input  logic               cmd_doubleword,
  input  logic [0:23]        cmd_address,
  input  logic [0:63]        cmd_data,
  output MMIOInterfaceInput  mmio_req,
  input  MMIOInterfaceOutput mmio_rsp,
  output logic               rsp_valid,
  output logic [0:63]        rsp_data,
  output logic [0:1]         rsp_status,
  output logic               spurious_ack
);

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [0:1] ST_OK       = 2'b00;
  localparam logic [0:1] ST_PARITY   = 2'b01;
  localparam logic [0:1] ST_TIMEOUT  = 2'b10;
  localparam logic [0:1] ST_MISALIGN = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESPOND} state_t;

  state_t      state;
  logic [15:0] wait_count;
  logic [0:63] issue_data;
  logic        misaligned;
  logic        rsp_parity_ok;

  // 32-bit writes replicate the low word onto both halves of the data bus.
  always_comb begin
    issue_data = '0;
    if (!cmd_read) begin
      if (cmd_doubleword) begin
        issue_data = cmd_data;
      end else begin
        issue_data = {cmd_data[32:63], cmd_data[32:63]};
      end
    end
  end

  assign misaligned    = cmd_doubleword && cmd_address[23];
  assign rsp_parity_ok = (mmio_rsp.data_parity == ~^mmio_rsp.data);

  // The issued mmio_req fields double as the latched command for the rest of
  // the transaction, so they hold until the next ISSUE.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      wait_count   <= '0;
      cmd_ready    <= 1'b0;
      mmio_req     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_status   <= ST_OK;
      spurious_ack <= 1'b0;
    end else begin
      spurious_ack <= mmio_rsp.ack && (state != WAIT_ACK);

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (misaligned) begin
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= ST_MISALIGN;
              state      <= RESPOND;
            end else begin
              mmio_req.valid          <= 1'b1;
              mmio_req.cfg            <= cmd_cfg;
              mmio_req.read           <= cmd_read;
              mmio_req.doubleword     <= cmd_doubleword;
              mmio_req.address        <= cmd_address;
              mmio_req.address_parity <= ~^cmd_address;
              mmio_req.data           <= issue_data;
              mmio_req.data_parity    <= ~^issue_data;
              state                   <= ISSUE;
            end
          end
        end

        ISSUE: begin
          mmio_req.valid <= 1'b0;
          wait_count     <= '0;
          state          <= WAIT_ACK;
        end

        // An ack in the final wait cycle takes priority over the timeout.
        WAIT_ACK: begin
          if (mmio_rsp.ack) begin
            rsp_valid <= 1'b1;
            state     <= RESPOND;
            if (mmio_req.read) begin
              rsp_data   <= mmio_rsp.data;
              rsp_status <= rsp_parity_ok ? ST_OK : ST_PARITY;
            end else begin
              rsp_data   <= '0;
              rsp_status <= ST_OK;
            end
          end else if (wait_count == LAST_WAIT) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_status <= ST_TIMEOUT;
            state      <= RESPOND;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end

        RESPOND: begin
          rsp_valid  <= 1'b0;
          rsp_data   <= '0;
          rsp_status <= ST_OK;
          cmd_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_master.sv
// Self-checking bench for mmio_master: directed vector table, hand-written
// reset/spurious sequences, and randomized transactions against a reference model.
module tb_mmio_master;
  import mmio_master_pkg::*;

  localparam int T = 8;
  localparam int WINDOW = T + 8;

  logic               clock = 1'b0;
  logic               rstn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_read = 1'b0;
  logic               cmd_cfg = 1'b0;
  logic               cmd_doubleword = 1'b0;
  logic [0:23]        cmd_address = '0;
  logic [0:63]        cmd_data = '0;
  MMIOInterfaceInput  mmio_req;
  MMIOInterfaceOutput mmio_rsp = '0;
  logic               rsp_valid;
  logic [0:63]        rsp_data;
  logic [0:1]         rsp_status;
  logic               spurious_ack;

  int total = 0;
  int bad = 0;

  mmio_master #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock),
    .rstn(rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_read(cmd_read),
    .cmd_cfg(cmd_cfg),
    .cmd_doubleword(cmd_doubleword),
    .cmd_address(cmd_address),
    .cmd_data(cmd_data),
    .mmio_req(mmio_req),
    .mmio_rsp(mmio_rsp),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .spurious_ack(spurious_ack)
  );

  always #5 clock = ~clock;

  // ack_cycle 0 means the responder never acks; cycle numbers count from the accept edge.
  typedef struct {
    bit          read;
    bit          cfg;
    bit          dw;
    logic [23:0] addr;
    logic [63:0] data;
    int          ack_cycle;
    logic [63:0] ack_data;
    bit          ack_par;
    int          rsp_cycle;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_status;
    int          spur_cycle;
  } vec_t;

  int                obs_rsp_count, obs_rsp_cycle, obs_issue_count, obs_issue_cycle;
  int                obs_spur_count, obs_spur_cycle;
  logic [63:0]       obs_rsp_data;
  logic [1:0]        obs_rsp_status;
  logic              obs_ready_c1, obs_ready_after;
  MMIOInterfaceInput obs_req;

  function automatic vec_t mk(bit rd, bit cf, bit dw, logic [23:0] a, logic [63:0] d,
                              int ac, logic [63:0] ad, bit ap, int rc,
                              logic [63:0] rdat, logic [1:0] rs, int sc);
    vec_t v;
    v.read = rd; v.cfg = cf; v.dw = dw; v.addr = a; v.data = d;
    v.ack_cycle = ac; v.ack_data = ad; v.ack_par = ap;
    v.rsp_cycle = rc; v.rsp_data = rdat; v.rsp_status = rs; v.spur_cycle = sc;
    return v;
  endfunction

  function automatic bit odd_par(logic [63:0] x);
    return ($countones(x) % 2) == 0;
  endfunction

  function automatic bit is_misaligned(vec_t v);
    return v.dw && (v.addr % 2 == 1);
  endfunction

  function automatic logic [63:0] exp_wdata(vec_t v);
    logic [63:0] d;
    d = v.data;
    if (v.read) return 64'd0;
    if (v.dw) return d;
    return {d[31:0], d[31:0]};
  endfunction

  // Transaction-level model: derives response timing and content from the command and ack timing.
  function automatic vec_t model(vec_t v);
    vec_t m;
    m = v;
    m.spur_cycle = 0;
    if (is_misaligned(v)) begin
      m.rsp_cycle = 1; m.rsp_data = 0; m.rsp_status = 2'd3;
    end else if (v.ack_cycle >= 2 && v.ack_cycle <= T + 1) begin
      m.rsp_cycle = v.ack_cycle + 1;
      if (v.read) begin
        m.rsp_data = v.ack_data;
        m.rsp_status = (v.ack_par == odd_par(v.ack_data)) ? 2'd0 : 2'd1;
      end else begin
        m.rsp_data = 0; m.rsp_status = 2'd0;
      end
    end else begin
      m.rsp_cycle = T + 2; m.rsp_data = 0; m.rsp_status = 2'd2;
    end
    if (v.ack_cycle != 0 && (is_misaligned(v) || v.ack_cycle > T + 1))
      m.spur_cycle = v.ack_cycle + 1;
    return m;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!cmd_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_output("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_read = v.read;
    cmd_cfg = v.cfg;
    cmd_doubleword = v.dw;
    cmd_address = v.addr;
    cmd_data = v.data;
    @(posedge clock);
    obs_rsp_count = 0; obs_rsp_cycle = -1; obs_issue_count = 0; obs_issue_cycle = -1;
    obs_spur_count = 0; obs_spur_cycle = -1; obs_rsp_data = '0; obs_rsp_status = '0;
    obs_ready_c1 = 1'bx; obs_ready_after = 1'bx; obs_req = '0;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clock);
      if (k == 1) begin
        cmd_valid = 1'b0;
        obs_ready_c1 = cmd_ready;
      end
      if (obs_rsp_count > 0 && k == obs_rsp_cycle + 1) obs_ready_after = cmd_ready;
      if (mmio_req.valid) begin
        obs_issue_count++; obs_issue_cycle = k; obs_req = mmio_req;
      end
      if (rsp_valid) begin
        obs_rsp_count++; obs_rsp_cycle = k; obs_rsp_data = rsp_data; obs_rsp_status = rsp_status;
      end
      if (spurious_ack) begin
        obs_spur_count++; obs_spur_cycle = k;
      end
      mmio_rsp.ack = (k == v.ack_cycle);
      mmio_rsp.data = v.ack_data;
      mmio_rsp.data_parity = v.ack_par;
    end
    mmio_rsp.ack = 1'b0;
  endtask

  task automatic verify(input vec_t e);
    check_output("rsp_count", obs_rsp_count, 1);
    check_output("rsp_cycle", obs_rsp_cycle, e.rsp_cycle);
    check_output("rsp_data", obs_rsp_data, e.rsp_data);
    check_output("rsp_status", obs_rsp_status, e.rsp_status);
    check_output("ready_c1", obs_ready_c1, 0);
    check_output("ready_after", obs_ready_after, 1);
    check_output("spur_count", obs_spur_count, (e.spur_cycle != 0) ? 1 : 0);
    if (e.spur_cycle != 0) check_output("spur_cycle", obs_spur_cycle, e.spur_cycle);
    check_output("issue_count", obs_issue_count, is_misaligned(e) ? 0 : 1);
    if (!is_misaligned(e)) begin
      check_output("issue_cycle", obs_issue_cycle, 1);
      check_output("req_cfg", obs_req.cfg, e.cfg);
      check_output("req_read", obs_req.read, e.read);
      check_output("req_dw", obs_req.doubleword, e.dw);
      check_output("req_addr", obs_req.address, e.addr);
      check_output("req_addr_par", obs_req.address_parity, odd_par(64'(e.addr)));
      check_output("req_data", obs_req.data, exp_wdata(e));
      check_output("req_data_par", obs_req.data_parity, odd_par(exp_wdata(e)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;

    vecs[0] = mk(1, 0, 1, 24'h000010, 64'h0, 5, 64'h0123_4567_89AB_CDEF, 1,
                 6, 64'h0123_4567_89AB_CDEF, 2'd0, 0);
    vecs[1] = mk(0, 0, 0, 24'h000021, 64'hFFFF_FFFF_DEAD_BEEF, 4, 64'h55, 0,
                 5, 64'h0, 2'd0, 0);
    vecs[2] = mk(1, 0, 0, 24'h000005, 64'h0, 3, 64'h1, 1,
                 4, 64'h1, 2'd1, 0);
    vecs[3] = mk(1, 0, 1, 24'h000040, 64'h0, 12, 64'h77, 0,
                 10, 64'h0, 2'd2, 13);
    vecs[4] = mk(1, 0, 1, 24'h000008, 64'h0, 9, 64'hA5, 1,
                 10, 64'hA5, 2'd0, 0);
    vecs[5] = mk(0, 0, 1, 24'h000003, 64'h1234, 0, 64'h0, 0,
                 1, 64'h0, 2'd3, 0);
    vecs[6] = mk(1, 1, 0, 24'h000007, 64'h0, 2, 64'hDEAD_BEEF_DEAD_BEEF, 1,
                 3, 64'hDEAD_BEEF_DEAD_BEEF, 2'd0, 0);
    vecs[7] = mk(0, 1, 0, 24'h000100, 64'hCAFE_F00D, 0, 64'h0, 0,
                 10, 64'h0, 2'd2, 0);

    repeat (3) @(negedge clock);
    check_output("reset_cmd_ready", cmd_ready, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_req_zero", (mmio_req == '0), 1);
    rstn = 1'b1;
    @(negedge clock);
    check_output("post_reset_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      verify(vecs[i]);
    end

    // Ack while idle must only produce a delayed spurious pulse.
    @(negedge clock);
    mmio_rsp.ack = 1'b1;
    @(negedge clock);
    mmio_rsp.ack = 1'b0;
    check_output("idle_spurious", spurious_ack, 1);
    check_output("idle_spur_ready", cmd_ready, 1);
    @(negedge clock);
    check_output("idle_spur_clear", spurious_ack, 0);

    // Reset during WAIT_ACK abandons the transaction without a response.
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_cfg = 1'b0; cmd_doubleword = 1'b1;
    cmd_address = 24'h000100; cmd_data = '0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    rstn = 1'b0;
    #1;
    check_output("midrst_req_zero", (mmio_req == '0), 1);
    check_output("midrst_rsp_valid", rsp_valid, 0);
    check_output("midrst_rsp_data", rsp_data, 0);
    check_output("midrst_rsp_status", rsp_status, 0);
    check_output("midrst_cmd_ready", cmd_ready, 0);
    check_output("midrst_spurious", spurious_ack, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("midrst_no_rsp", rsp_valid, 0);
    end
    rstn = 1'b1;
    @(negedge clock);
    check_output("midrst_ready_back", cmd_ready, 1);
    v = mk(1, 0, 1, 24'h000020, 64'h0, 3, 64'h3, 1, 4, 64'h3, 2'd0, 0);
    apply_stimulus(v);
    verify(v);

    for (int i = 0; i < 40; i++) begin
      int r;
      v.read = 1'($urandom);
      v.cfg = 1'($urandom);
      v.dw = 1'($urandom);
      v.addr = 24'($urandom);
      v.data = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      v.ack_cycle = (r < 2) ? 0 : $urandom_range(2, T + 4);
      v.ack_data = {$urandom, $urandom};
      v.ack_par = odd_par(v.ack_data) ^ ($urandom_range(0, 3) == 0);
      v = model(v);
      apply_stimulus(v);
      verify(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
